// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single fixed-latency unified memory port between the IF stage
//   (fetch) and the MEM stage (load/store). A granted access is held stable on
//   the memory bus for MEM_LATENCY cycles, read data is captured on the last
//   access cycle, and a one-cycle ack is returned in the following cycle.
//   Fetches cancelled by i_flush still finish on the bus but are not acked.
//
//   Optional build macro: ARB_FAIR_EN
//     defined   - alternate grants when both requesters are pending
//     undefined - data port has fixed priority over fetch
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   i_req/i_addr/i_flush  fetch request, address, cancel
//   i_rdata/i_ack         fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (we=1 store)
//   d_rdata/d_ack         load word and completion pulse
//   m_read/m_write/m_addr/m_wdata/m_rdata  memory port
//   busy                  high while an access is in ACCESS or RESP
//   owner_d               1 when the current/last grant went to the data port
module mem_port_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic                 i_flush,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic                 m_read,
    output logic                 m_write,
    output logic [WORD_SIZE-1:0] m_addr,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata,
    output logic                 busy,
    output logic                 owner_d
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 m_read_q, m_read_d;
    logic                 m_write_q, m_write_d;
    logic [WORD_SIZE-1:0] m_addr_q, m_addr_d;
    logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;
    logic                 busy_q, busy_d;
    logic                 owner_d_q, owner_d_d;
    logic                 drop_q, drop_d;
`ifdef ARB_FAIR_EN
    logic                 last_d_q, last_d_d;
`endif

    logic i_valid;
    logic grant_d;

    // A fetch raised together with a flush is not a real request.
    always_comb begin
        i_valid = i_req && !i_flush;
`ifdef ARB_FAIR_EN
        // Under contention, hand the port to whoever did not get it last.
        grant_d = d_req && (!i_valid || !last_d_q);
`else
        grant_d = d_req;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        busy_d    = busy_q;
        owner_d_d = owner_d_q;
        drop_d    = drop_q;
`ifdef ARB_FAIR_EN
        last_d_d  = last_d_q;
`endif

        case (state_q)
            IDLE: begin
                if (d_req || i_valid) begin
                    state_d   = ACCESS;
                    cnt_d     = CNT_INIT;
                    busy_d    = 1'b1;
                    owner_d_d = grant_d;
                    drop_d    = 1'b0;
                    m_addr_d  = grant_d ? d_addr : i_addr;
                    m_wdata_d = grant_d ? d_wdata : '0;
                    m_write_d = grant_d && d_we;
                    m_read_d  = !(grant_d && d_we);
`ifdef ARB_FAIR_EN
                    last_d_d  = grant_d;
`endif
                end
            end

            ACCESS: begin
                if (!owner_d_q && i_flush) begin
                    drop_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    if (owner_d_q) begin
                        d_ack_d = 1'b1;
                        if (!m_write_q) begin
                            d_rdata_d = m_rdata;
                        end
                    end else if (!(drop_q || i_flush)) begin
                        // A flush in the final access cycle must also cancel.
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                drop_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
            owner_d_q <= 1'b0;
            drop_q    <= 1'b0;
`ifdef ARB_FAIR_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            busy_q    <= busy_d;
            owner_d_q <= owner_d_d;
            drop_q    <= drop_d;
`ifdef ARB_FAIR_EN
            last_d_q  <= last_d_d;
`endif
        end
    end

    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign busy    = busy_q;
    assign owner_d = owner_d_q;

endmodule
